// File: rtl/erdiv8_seq.sv
// Sequential radix-2 restoring divider: 2*DW-bit dividend / DW-bit divisor, with run-time
// truncation of the low quotient iterations. Optional early exit: ERDIV8_EARLY_EXIT_EN.
module erdiv8_seq #(
    parameter int unsigned DW = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*DW-1:0]        dat_in_n,
    input  logic [DW-1:0]          dat_in_d,
    input  logic [$clog2(DW)-1:0]  trunc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          quo_o,
    output logic [DW-1:0]          rem_o,
    output logic                   div0_o,
    output logic                   ovf_o
);

    localparam int unsigned KW = $clog2(DW);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          r_state, w_state_nxt;
    logic [DW-1:0]   r_nl;      // low dividend bits still to be shifted in
    logic [DW-1:0]   r_d;
    logic [KW-1:0]   r_t;
    logic [KW-1:0]   r_k;
    logic [DW-1:0]   r_p;
    logic [DW-1:0]   r_q;
    logic [DW-1:0]   r_quo;
    logic [DW-1:0]   r_rem;
    logic            r_div0;
    logic            r_ovf;

    logic            w_accept;
    logic            w_div0;
    logic            w_ovf;
    logic [DW:0]     w_p_shift;
    logic            w_ge;
    logic [DW-1:0]   w_p_new;
    logic [DW-1:0]   w_q_new;
    logic            w_last;
    logic            w_finish;

    assign w_accept  = in_valid & in_ready;
    assign w_div0    = (dat_in_d == '0);
    assign w_ovf     = (dat_in_n[2*DW-1:DW] >= dat_in_d);

    // One restoring iteration for quotient bit r_k
    assign w_p_shift = {r_p, r_nl[r_k]};
    assign w_ge      = (w_p_shift >= {1'b0, r_d});
    assign w_p_new   = w_ge ? DW'(w_p_shift - {1'b0, r_d}) : w_p_shift[DW-1:0];
    assign w_last    = (r_k == r_t);

    always_comb begin
        w_q_new      = r_q;
        w_q_new[r_k] = w_ge;
    end

`ifdef ERDIV8_EARLY_EXIT_EN
    logic [DW-1:0] w_rest_mask;

    // Dividend bits in [t, k-1] that remain to be shifted in
    assign w_rest_mask = ((DW'(1) << r_k) - DW'(1)) & ~((DW'(1) << r_t) - DW'(1));
    assign w_finish    = w_last | ((w_p_new == '0) && ((r_nl & w_rest_mask) == '0));
`else
    assign w_finish    = w_last;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_nxt = (w_div0 || w_ovf) ? StDone : StCalc;
                end
            end
            StCalc: begin
                if (w_finish) begin
                    w_state_nxt = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == StIdle);
        out_valid = (r_state == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nl   <= '0;
            r_d    <= '0;
            r_t    <= '0;
            r_k    <= '0;
            r_p    <= '0;
            r_q    <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
            r_div0 <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_nl <= dat_in_n[DW-1:0];
                        r_d  <= dat_in_d;
                        r_t  <= trunc;
                        r_k  <= KW'(DW - 1);
                        r_p  <= dat_in_n[2*DW-1:DW];
                        r_q  <= '0;
                        if (w_div0) begin
                            r_quo  <= '1;
                            r_rem  <= dat_in_n[DW-1:0];
                            r_div0 <= 1'b1;
                            r_ovf  <= 1'b0;
                        end else if (w_ovf) begin
                            r_quo  <= '1;
                            r_rem  <= '0;
                            r_div0 <= 1'b0;
                            r_ovf  <= 1'b1;
                        end
                    end
                end
                StCalc: begin
                    r_p <= w_p_new;
                    r_q <= w_q_new;
                    r_k <= r_k - KW'(1);
                    if (w_finish) begin
                        r_quo  <= w_q_new;
                        r_rem  <= w_p_new;
                        r_div0 <= 1'b0;
                        r_ovf  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quo_o  = r_quo;
    assign rem_o  = r_rem;
    assign div0_o = r_div0;
    assign ovf_o  = r_ovf;

endmodule

// File: tb/tb_erdiv8_seq.sv
// Self-checking bench for erdiv8_seq: vector table, random operands checked against an
// arithmetic model, backpressure and mid-calculation reset sequences.
module tb_erdiv8_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] dat_in_n = '0;
    logic [7:0]  dat_in_d = '0;
    logic [2:0]  trunc = '0;
    logic        in_ready;
    logic        out_valid;
    logic [7:0]  quo_o;
    logic [7:0]  rem_o;
    logic        div0_o;
    logic        ovf_o;

    erdiv8_seq #(.DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dat_in_n  (dat_in_n),
        .dat_in_d  (dat_in_d),
        .trunc     (trunc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quo_o     (quo_o),
        .rem_o     (rem_o),
        .div0_o    (div0_o),
        .ovf_o     (ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] n;
        logic [7:0]  d;
        logic [2:0]  t;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        div0;
        logic        ovf;
        int          lat;   // edges after accept until out_valid; -1 = unchecked
        int          hold;  // cycles of out_ready=0 after out_valid
    } vec_t;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       div0;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t model(input logic [15:0] n, input logic [7:0] d, input logic [2:0] t);
        vec_t v;
        int   ns;
        v.n = n; v.d = d; v.t = t; v.hold = 0;
        v.div0 = 1'b0; v.ovf = 1'b0;
        if (d == 8'd0) begin
            v.q = 8'hFF; v.r = n[7:0]; v.div0 = 1'b1; v.lat = 0;
        end else if (n[15:8] >= d) begin
            v.q = 8'hFF; v.r = 8'h00; v.ovf = 1'b1; v.lat = 0;
        end else begin
            ns  = int'(n) >> t;
            v.q = 8'((ns / int'(d)) << t);
            v.r = 8'(ns % int'(d));
`ifdef ERDIV8_EARLY_EXIT_EN
            v.lat = -1;
`else
            v.lat = 8 - int'(t);
`endif
        end
        return v;
    endfunction

    task automatic run_op(input vec_t v);
        exp_t e;
        int   edges;
        logic [7:0] q0, r0;
        e.q = v.q; e.r = v.r; e.div0 = v.div0; e.ovf = v.ovf;
        sb.push_back(e);
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1; dat_in_n = v.n; dat_in_d = v.d; trunc = v.t;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dat_in_n = 16'($urandom); dat_in_d = 8'($urandom); trunc = 3'($urandom);
        edges = 0;
        @(negedge clk);
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (!out_valid) begin
            check("timeout", 32'(out_valid), 32'd1);
            void'(sb.pop_front());
            return;
        end
        if (v.lat >= 0) check("latency", 32'(edges), 32'(v.lat));
        q0 = quo_o; r0 = rem_o;
        for (int i = 0; i < v.hold; i++) begin
            in_valid = 1'b1;
            dat_in_n = 16'($urandom); dat_in_d = 8'($urandom | 1);
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_quo", 32'(quo_o), 32'(q0));
            check("hold_rem", 32'(rem_o), 32'(r0));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        e = sb.pop_front();
        check("quo", 32'(quo_o), 32'(e.q));
        check("rem", 32'(rem_o), 32'(e.r));
        check("div0", 32'(div0_o), 32'(e.div0));
        check("ovf", 32'(ovf_o), 32'(e.ovf));
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("out_valid_clr", 32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
        check("quo_kept", 32'(quo_o), 32'(e.q));
    endtask

    vec_t tbl[7];
    vec_t v;

    initial begin
        tbl[0] = '{16'd1000, 8'd7, 3'd0, 8'd142, 8'd6, 1'b0, 1'b0, 8, 3};
        tbl[1] = '{16'd1000, 8'd7, 3'd3, 8'd136, 8'd6, 1'b0, 1'b0, 5, 0};
        tbl[2] = '{16'h1234, 8'd0, 3'd0, 8'hFF, 8'h34, 1'b1, 1'b0, 0, 0};
        tbl[3] = '{16'h0800, 8'd8, 3'd0, 8'hFF, 8'h00, 1'b0, 1'b1, 0, 0};
`ifdef ERDIV8_EARLY_EXIT_EN
        tbl[4] = '{16'h0100, 8'd2, 3'd0, 8'h80, 8'h00, 1'b0, 1'b0, 1, 0};
`else
        tbl[4] = '{16'h0100, 8'd2, 3'd0, 8'h80, 8'h00, 1'b0, 1'b0, 8, 0};
`endif
        tbl[5] = '{16'h00FE, 8'hFF, 3'd0, 8'h00, 8'hFE, 1'b0, 1'b0, 8, 1};
        tbl[6] = '{16'h7FFF, 8'h80, 3'd7, 8'h80, 8'h7F, 1'b0, 1'b0, 1, 0};

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_quo", 32'(quo_o), 32'd0);
        check("rst_rem", 32'(rem_o), 32'd0);
        check("rst_flags", 32'({div0_o, ovf_o}), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_op(tbl[i]);

        // Reset three edges into a calculation drops the result
        @(negedge clk);
        in_valid = 1'b1; dat_in_n = 16'd1000; dat_in_d = 8'd7; trunc = 3'd0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_quo", 32'(quo_o), 32'd0);
        check("midrst_rem", 32'(rem_o), 32'd0);
        check("midrst_flags", 32'({div0_o, ovf_o}), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(model(16'd1000, 8'd7, 3'd0));

        for (int i = 0; i < 24; i++) begin
            v = model(16'($urandom), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
            if (i % 3 == 0) v = model({8'($urandom_range(0, 100)), 8'($urandom)},
                                      8'($urandom_range(101, 255)), 3'($urandom_range(0, 7)));
            run_op(v);
        end

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
